// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared widths and types for the audio output path
package audio_pkg;
  localparam int AUDIO_SAMPLE_W = 16;
  localparam int I2S_SLOT_BITS  = 32;
  localparam int I2S_FRAME_BITS = 64;
  localparam int PSG_OUT_W      = 23;
  localparam int BIT_CNT_W      = $clog2(I2S_FRAME_BITS);

  typedef logic signed [AUDIO_SAMPLE_W-1:0] sample_t;
  typedef logic [BIT_CNT_W-1:0]             bit_cnt_t;
endpackage

// File: rtl/audio_sat.sv
// rtl/audio_sat.sv - arithmetic right shift followed by signed saturation
module audio_sat #(
  parameter int IN_W  = 23,
  parameter int OUT_W = 16,
  parameter int SHIFT = 6
) (
  input  logic signed [IN_W-1:0]  i_x,
  output logic signed [OUT_W-1:0] o_y
);
  localparam logic signed [IN_W-1:0] MAX_V = IN_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [IN_W-1:0] MIN_V = ~MAX_V;

  logic signed [IN_W-1:0] w_y;

  assign w_y = i_x >>> SHIFT;

  always_comb begin
    o_y = w_y[OUT_W-1:0];
    if (w_y > MAX_V) begin
      o_y = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_y < MIN_V) begin
      o_y = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end
endmodule

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - paces the PSG once per frame and serialises 16-bit
// saturated left/right samples as a Philips I2S stream
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 4,
  parameter int SHIFT    = 6
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic signed [PSG_OUT_W-1:0] i_left_in,
  input  logic signed [PSG_OUT_W-1:0] i_right_in,
  output logic                        o_next_sample,
  output logic                        o_i2s_bclk,
  output logic                        o_i2s_lrck,
  output logic                        o_i2s_data
);
  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  bit_cnt_t         r_bit_cnt;
  logic             r_bclk;
  logic             r_lrck;
  logic             r_data;
  logic             r_next_sample;
  sample_t          r_hold_l;
  sample_t          r_hold_r;

  logic     w_tick;
  bit_cnt_t w_bit_nxt;
  sample_t  w_slot;
  logic [3:0] w_idx;
  logic     w_data_nxt;
  sample_t  w_sat_l;
  sample_t  w_sat_r;

  audio_sat #(.IN_W(PSG_OUT_W), .OUT_W(AUDIO_SAMPLE_W), .SHIFT(SHIFT)) u_sat_l (
    .i_x (i_left_in),
    .o_y (w_sat_l)
  );

  audio_sat #(.IN_W(PSG_OUT_W), .OUT_W(AUDIO_SAMPLE_W), .SHIFT(SHIFT)) u_sat_r (
    .i_x (i_right_in),
    .o_y (w_sat_r)
  );

  assign w_tick    = (r_div_cnt == DIV_LAST);
  assign w_bit_nxt = r_bit_cnt + BIT_CNT_W'(1);
  assign w_slot    = w_bit_nxt[BIT_CNT_W-1] ? r_hold_r : r_hold_l;
  assign w_idx     = 4'(5'd16 - w_bit_nxt[4:0]);

  // Slot bit 0 is the one-BCLK I2S delay; the word occupies bits 1..16.
  always_comb begin
    w_data_nxt = 1'b0;
    if (w_bit_nxt[4:0] >= 5'd1 && w_bit_nxt[4:0] <= 5'd16) begin
      w_data_nxt = w_slot[w_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt     <= '0;
      r_bit_cnt     <= '1;
      r_bclk        <= 1'b0;
      r_lrck        <= 1'b0;
      r_data        <= 1'b0;
      r_next_sample <= 1'b0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
    end else begin
      r_next_sample <= 1'b0;
      r_div_cnt     <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      if (w_tick) begin
        r_bclk <= ~r_bclk;
        // Falling edge: advance the bit and present the next data bit.
        if (r_bclk) begin
          r_bit_cnt <= w_bit_nxt;
          r_lrck    <= w_bit_nxt[BIT_CNT_W-1];
          r_data    <= w_data_nxt;
          if (w_bit_nxt == '0) begin
            r_hold_l      <= w_sat_l;
            r_hold_r      <= w_sat_r;
            r_next_sample <= 1'b1;
          end
        end
      end
    end
  end

  assign o_next_sample = r_next_sample;
  assign o_i2s_bclk    = r_bclk;
  assign o_i2s_lrck    = r_lrck;
  assign o_i2s_data    = r_data;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb/tb_audio_i2s_tx.sv - bench for audio_i2s_tx at BCLK_DIV=4/SHIFT=6 and
// BCLK_DIV=1/SHIFT=0, with a cycle-level reference model
module tb_audio_i2s_tx;
  logic        clk = 1'b0;
  logic        rst [2];
  logic [22:0] l_in [2];
  logic [22:0] r_in [2];
  logic        ns_o [2];
  logic        bclk_o [2];
  logic        lrck_o [2];
  logic        data_o [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  int          t_m [2];
  logic [15:0] h_l [2];
  logic [15:0] h_r [2];

  always #5 clk = ~clk;

  audio_i2s_tx #(.BCLK_DIV(4), .SHIFT(6)) dut (
    .i_clk(clk), .i_rst(rst[0]), .i_left_in(l_in[0]), .i_right_in(r_in[0]),
    .o_next_sample(ns_o[0]), .o_i2s_bclk(bclk_o[0]), .o_i2s_lrck(lrck_o[0]),
    .o_i2s_data(data_o[0])
  );

  audio_i2s_tx #(.BCLK_DIV(1), .SHIFT(0)) dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_left_in(l_in[1]), .i_right_in(r_in[1]),
    .o_next_sample(ns_o[1]), .o_i2s_bclk(bclk_o[1]), .o_i2s_lrck(lrck_o[1]),
    .o_i2s_data(data_o[1])
  );

  function automatic int n_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int sh_of(input int d);
    return (d == 0) ? 6 : 0;
  endfunction

  function automatic logic [15:0] ref_sat(input logic [22:0] x, input int sh);
    int xi, y;
    xi = $signed(x);
    y  = xi >>> sh;
    if (y > 32767) return 16'h7FFF;
    if (y < -32768) return 16'h8000;
    return y[15:0];
  endfunction

  function automatic bit frame_edge(input int t, input int n);
    return (t > 0) && (t % (2 * n) == 0) && (((t / (2 * n)) - 1) % 64 == 0);
  endfunction

  // Expected {next_sample, bclk, lrck, data} after clock edge t since release.
  function automatic logic [3:0] ref_out(input int t, input int n,
                                         input logic [15:0] hl, input logic [15:0] hr);
    int k, b, p;
    logic bc, ns, lr, dt;
    logic [15:0] w;
    bc = ((t / n) % 2) == 1;
    k  = t / (2 * n);
    if (k == 0) return {1'b0, bc, 2'b00};
    b  = (k - 1) % 64;
    ns = (t % (2 * n) == 0) && (b == 0);
    lr = (b >= 32);
    p  = b % 32;
    w  = lr ? hr : hl;
    dt = (p >= 1 && p <= 16) ? w[16 - p] : 1'b0;
    return {ns, bc, lr, dt};
  endfunction

  function automatic logic [3:0] outs(input int d);
    return {ns_o[d], bclk_o[d], lrck_o[d], data_o[d]};
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        t_m[d] = 0;
      end else begin
        t_m[d] = t_m[d] + 1;
        if (frame_edge(t_m[d], n_of(d))) begin
          h_l[d] = ref_sat(l_in[d], sh_of(d));
          h_r[d] = ref_sat(r_in[d], sh_of(d));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [3:0] e;
        e = ref_out(t_m[d], n_of(d), h_l[d], h_r[d]);
        checks++;
        if (outs(d) !== e) begin
          errors++;
          $display("FAIL model_d%0d t=%0d: got %b expected %b", d, t_m[d], outs(d), e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for the next frame edge, then samples 64 bits at BCLK rising edges.
  task automatic decode_frame(input int d, input bit glitch, input logic [22:0] gval,
                              output logic [15:0] wl, output logic [15:0] wr,
                              output bit tail_ok, output bit ok);
    int n, cnt;
    logic [63:0] s;
    logic pb;
    ok = 1'b0; tail_ok = 1'b1; s = '0; wl = '0; wr = '0; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ns_o[d] && n < 3000);
    if (!ns_o[d]) return;
    pb = bclk_o[d]; cnt = 0; n = 0;
    while (cnt < 64 && n < 1000) begin
      @(negedge clk);
      n++;
      if (bclk_o[d] && !pb) begin
        s[cnt] = data_o[d];
        cnt++;
        if (glitch && cnt == 4) l_in[d] = gval;
      end
      pb = bclk_o[d];
    end
    if (cnt < 64) return;
    for (int j = 1; j <= 16; j++) begin
      wl[16 - j] = s[j];
      wr[16 - j] = s[32 + j];
    end
    if (s[0] || s[32] || (s[31:17] != '0) || (s[63:49] != '0)) tail_ok = 1'b0;
    ok = 1'b1;
  endtask

  typedef struct {
    logic [22:0] l;
    logic [22:0] r;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  initial begin
    vec_t vt [6];
    int   q_ns0 [$], q_br0 [$], q_lr0 [$], q_ns1 [$], q_br1 [$];
    logic pb0, pl0, pb1, pb;
    logic [15:0] wl, wr;
    bit tail_ok, ok;
    int n, f, ones;

    vt[0] = '{23'd64000,    23'h7FFFC0, 16'h03E8, 16'hFFFF};
    vt[1] = '{23'h3FFFFF,   23'h400000, 16'h7FFF, 16'h8000};
    vt[2] = '{23'h1FFFC0,   23'h600000, 16'h7FFF, 16'h8000};
    vt[3] = '{23'h200000,   23'h5FFFFF, 16'h7FFF, 16'h8000};
    vt[4] = '{23'd63,       23'h7FFFBF, 16'h0000, 16'hFFFE};
    vt[5] = '{23'h00ABCD,   23'd0,      16'h02AF, 16'h0000};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; l_in[d] = '0; r_in[d] = '0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_outs_d0", outs(0), 0);
    chk("reset_outs_d1", outs(1), 0);
    rst[0] = 1'b0; rst[1] = 1'b0;

    pb0 = 1'b0; pl0 = 1'b0; pb1 = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (ns_o[0]) q_ns0.push_back(c);
      if (bclk_o[0] && !pb0) q_br0.push_back(c);
      if (lrck_o[0] && !pl0) q_lr0.push_back(c);
      if (ns_o[1]) q_ns1.push_back(c);
      if (bclk_o[1] && !pb1) q_br1.push_back(c);
      pb0 = bclk_o[0]; pl0 = lrck_o[0]; pb1 = bclk_o[1];
    end
    chk("ns_edge_1",   (q_ns0.size() > 0) ? q_ns0[0] : -1, 8);
    chk("ns_edge_2",   (q_ns0.size() > 1) ? q_ns0[1] : -1, 520);
    chk("ns_edge_3",   (q_ns0.size() > 2) ? q_ns0[2] : -1, 1032);
    chk("bclk_rise_1", (q_br0.size() > 0) ? q_br0[0] : -1, 4);
    chk("bclk_period", (q_br0.size() > 1) ? q_br0[1] - q_br0[0] : -1, 8);
    chk("lrck_rise_1", (q_lr0.size() > 0) ? q_lr0[0] : -1, 264);
    chk("lrck_period", (q_lr0.size() > 1) ? q_lr0[1] - q_lr0[0] : -1, 512);
    chk("n1_ns_first", (q_ns1.size() > 0) ? q_ns1[0] : -1, 2);
    chk("n1_frame",    (q_ns1.size() > 1) ? q_ns1[1] - q_ns1[0] : -1, 128);
    chk("n1_bclk_per", (q_br1.size() > 1) ? q_br1[1] - q_br1[0] : -1, 2);

    for (int i = 0; i < 6; i++) begin
      l_in[0] = vt[i].l; r_in[0] = vt[i].r;
      decode_frame(0, 1'b0, '0, wl, wr, tail_ok, ok);
      chk($sformatf("vec%0d_done", i), ok, 1);
      chk($sformatf("vec%0d_left", i), wl, vt[i].el);
      chk($sformatf("vec%0d_right", i), wr, vt[i].er);
      chk($sformatf("vec%0d_tail", i), tail_ok, 1);
    end

    l_in[0] = 23'd64000; r_in[0] = 23'h7FFFC0;
    decode_frame(0, 1'b1, 23'h3FFFFF, wl, wr, tail_ok, ok);
    chk("glitch_done", ok, 1);
    chk("glitch_left", wl, 16'h03E8);
    decode_frame(0, 1'b0, '0, wl, wr, tail_ok, ok);
    chk("glitch_next", wl, 16'h7FFF);

    l_in[0] = 23'd64000; r_in[0] = 23'h7FFFC0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ns_o[0] && n < 3000);
    chk("rst_seq_ns", ns_o[0], 1);
    pb = bclk_o[0]; f = 0; n = 0;
    while (f < 40 && n < 2000) begin
      @(negedge clk);
      n++;
      if (!bclk_o[0] && pb) f++;
      pb = bclk_o[0];
    end
    chk("rst_seq_lrck40", lrck_o[0], 1);
    l_in[0] = '0; r_in[0] = '0;
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("rst_outs_zero", outs(0), 0);
    n = 0; ones = 0;
    do begin
      @(negedge clk);
      n++;
      if (data_o[0]) ones++;
    end while (!ns_o[0] && n < 100);
    chk("rst_ns_delay", n, 8);
    repeat (500) begin
      @(negedge clk);
      if (data_o[0]) ones++;
    end
    chk("rst_first_frame_zero", ones, 0);

    l_in[1] = 23'h001234; r_in[1] = 23'h7F8000;
    decode_frame(1, 1'b0, '0, wl, wr, tail_ok, ok);
    chk("n1_done", ok, 1);
    chk("n1_left", wl, 16'h1234);
    chk("n1_right", wr, 16'h8000);
    chk("n1_tail", tail_ok, 1);

    repeat (4000) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if ($urandom_range(0, 39) == 0) begin
          if ($urandom_range(0, 1) == 0) begin
            l_in[d] = 23'($urandom);
            r_in[d] = 23'($urandom);
          end else begin
            l_in[d] = 23'($signed(21'($urandom)));
            r_in[d] = 23'($signed(17'($urandom)));
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Audio output stage directly downstream of the PSG. It paces the PSG by issuing a one-cycle `next_sample` strobe once per audio frame. At that frame edge it captures the PSG's 23-bit signed left/right sums, scales and saturates them to 16-bit signed, and shifts them out as a standard Philips I2S stream (BCLK, LRCK, SDATA) to the external DAC.

## Interface
- `BCLK_DIV`, default 4: clk cycles per BCLK half-period; must be ≥1. The frame is 128·BCLK_DIV clk, so 25 MHz / 512 = 48.828 kHz at the default.
- `SHIFT`, default 6: arithmetic right shift applied to the inputs before saturation; range 0..7.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `left_in`  in  23  signed left sample; the PSG's left output.
- `right_in`  in  23  signed right sample; the PSG's right output.
- `next_sample`  out  1  one-clk pulse at each frame start; drives the PSG's `next_sample`.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrck`  out  1  word select: 0 = left slot, 1 = right slot.
- `i2s_data`  out  1  serial data, MSB first.

## Operation
- Internal state:
  - `div_cnt`: 0..BCLK_DIV-1.
  - `bit_cnt`: 6 bits, 0..63.
  - `bclk_r`.
  - `hold_l`, `hold_r`: 16-bit signed frame holding registers.
- Tick: asserted when `div_cnt == BCLK_DIV-1`. On a tick `div_cnt` wraps to 0; otherwise it increments.
- Each tick toggles `bclk_r`.
  - Rising edge (`bclk_r` goes 0→1): nothing else changes; the DAC samples here.
  - Falling edge (`bclk_r` goes 1→0): `bit_cnt` increments, wrapping 63→0, and the outputs are recomputed from the new count.
- Outputs are registered and updated only on a falling-edge tick:
  - `i2s_lrck = bit_cnt[5]`.
  - `i2s_data = slot[16 - bit_cnt[4:0]]` for `bit_cnt[4:0]` in 1..16, else 0. `slot` is `hold_l` when `bit_cnt[5] == 0`, else `hold_r`.
  - This gives 32 BCLK per slot and a 16-bit word left-justified after the standard one-BCLK I2S delay.
- Frame edge: the falling-edge tick on which `bit_cnt` becomes 0. In that same cycle:
  - `hold_l <= sat(left_in)` and `hold_r <= sat(right_in)`.
  - `next_sample` is 1 for exactly that cycle and 0 in every other cycle.
- Inputs are sampled only at the frame edge. Changes at any other time are ignored. The PSG result produced in response to a strobe is therefore played one frame later, by design.
- `sat(x)`:
  - `y = x >>> SHIFT`, which truncates toward −∞.
  - If y > 32767, output 16'h7FFF.
  - If y < −32768, output 16'h8000.
  - Otherwise output `y[15:0]`.

## Timing
- Reset values:
  - Outputs: `i2s_bclk = 0`, `i2s_lrck = 0`, `i2s_data = 0`, `next_sample = 0`.
  - Internal: `div_cnt = 0`, `bit_cnt = 63`, `hold_l = hold_r = 0`.
- After rst deasserts, count clock edges from edge 1:
  - BCLK rises at edge N = BCLK_DIV.
  - BCLK falls at edge 2N. This is the first frame edge: `next_sample` pulses and LRCK = 0.
- Thereafter `next_sample` pulses every 128·N clk.
- LRCK changes only on BCLK falling edges:
  - It goes high at `bit_cnt` 32 and low at `bit_cnt` 0.
  - Each LRCK half lasts 64·N clk.
- Input-to-serial latency: the MSB appears one BCLK period, 2N clk, after the frame edge.
- Reset asserted mid-frame:
  - All registers return to their reset values on the next clk edge.
  - The partial frame is dropped. The PSG may still be mid-sequence; it completes harmlessly.
- N=1: BCLK toggles every clk, i.e. BCLK = clk/2. This is legal.

## Structure
- Shared package `audio_pkg`:
  - `AUDIO_SAMPLE_W = 16`.
  - `I2S_SLOT_BITS = 32`.
  - `I2S_FRAME_BITS = 64`.
  - `PSG_OUT_W = 23`.
- Sub-module `audio_sat`:
  - Parameters `IN_W`, `OUT_W`, `SHIFT`.
  - Combinational shift-and-saturate.
  - Instantiated twice, once per channel.
- Top level holds the divider, the bit counter, the holding registers and the output muxing.

## Test plan
- Reset release, defaults: `next_sample` first high exactly at edge 8, then at edges 520, 1032; BCLK period 8 clk; LRCK period 512 clk.
- `left_in = 64000`, `right_in = −64` held: left slot serialises 16'h03E8; right slot serialises 16'hFFFF; bits 17..31 of each slot are 0.
- Saturation: `left_in = 23'h3FFFFF` → 16'h7FFF; `right_in = 23'h400000` → 16'h8000.
- Input glitch: change `left_in` between frame edges; the serialised word reflects only the value present in the `next_sample` cycle.
- Assert rst for 1 clk at `bit_cnt` 40 with nonzero holds: all outputs 0 next cycle; next `next_sample` 2N clk after release; first frame data is 0.
- `BCLK_DIV = 1`, `SHIFT = 0`, `left_in = 16'h1234`: BCLK = clk/2; frame 128 clk; left word 16'h1234 bit-exact.
